// File: rtl/tx_tag_pkg.sv
// -----------------------------------------------------------------------------
// tx_tag_pkg
// Shared definitions for the egress header editor: the editor FSM state
// encoding, tag constants and header offsets, and the helper that picks the
// next insertion state after the address bytes (or a stripped tag) are done.
// -----------------------------------------------------------------------------
package tx_tag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_STRIP    = 3'd2,
    ST_INS_VLAN = 3'd3,
    ST_INS_RTAG = 3'd4,
    ST_PAYLOAD  = 3'd5,
    ST_DISCARD  = 3'd6
  } tx_state_e;

  localparam logic [15:0] VLAN_TPID           = 16'h8100;
  localparam logic [15:0] RTAG_ETHERTYPE_DFLT = 16'hF1C1;

  // Byte index of the last SMAC byte; the tag area starts right after it.
  localparam logic [3:0]  SMAC_END  = 4'd11;
  localparam int          TAG_LEN   = 4;
  localparam int          RTAG_LEN  = 6;

  // Insertion order is fixed: VLAN tag first, then R-TAG, then the frame's
  // own EtherType/payload.
  function automatic tx_state_e tag_next(input logic ins_vlan,
                                         input logic ins_rtag);
    if (ins_vlan) return ST_INS_VLAN;
    if (ins_rtag) return ST_INS_RTAG;
    return ST_PAYLOAD;
  endfunction

endpackage

// File: rtl/axis_byte_reg.sv
// -----------------------------------------------------------------------------
// axis_byte_reg
// Single output register stage for a byte stream with last/err sidebands.
// The producer may load only when can_load is high; while out_valid is high
// and out_ready is low, data/last/err are held unchanged.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   load           write load_data/load_last/load_err into the register
//   load_data      byte to register
//   load_last      end-of-frame marker for that byte
//   load_err       abort marker for that byte
//   can_load       register empty or being drained this cycle
//   out_data       registered byte
//   out_valid      register holds a byte
//   out_last       registered end-of-frame marker
//   out_err        registered abort marker
//   out_ready      downstream accepts the registered byte
// -----------------------------------------------------------------------------
module axis_byte_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         load_err,
  output logic         can_load,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  output logic         out_err,
  input  logic         out_ready
);

  assign can_load = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
      out_last  <= load_last;
      out_err   <= load_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_frm_tag_edit.sv
// -----------------------------------------------------------------------------
// tx_frm_tag_edit
// Egress header editor. Per frame, a metadata word selects whether to strip
// an existing 802.1Q tag (bytes 12-15), insert a new 802.1Q tag after the
// SMAC, and/or insert an 802.1CB R-TAG after that. Frames are discarded when
// the port link is down at the metadata handshake. FCS is added downstream.
//
// Handshakes: every stream/metadata transfer happens on a rising clock edge
// where valid and ready are both high; a producer holding valid keeps its
// data stable until that edge, and ready never depends on the same-cycle
// valid of the channel it qualifies.
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_mac_port_link           link status, sampled at metadata handshake
//   i_meta_vld/o_meta_ready   metadata handshake
//   i_meta_*                  strip/insert flags, VLAN PCP/VID, R-TAG seq
//   i_mac_axi_data*           input frame byte stream, o_mac_axi_data_ready
//   o_mac_axi_data*           edited frame stream to the TX MAC, err = abort
//   o_frm_done                pulse per completed (or discarded) frame
//   o_dbg_state               current editor FSM state
// -----------------------------------------------------------------------------
module tx_frm_tag_edit
  import tx_tag_pkg::*;
#(
  parameter int          PORT_MNG_DATA_WIDTH = 8,
  parameter logic [15:0] RTAG_ETHERTYPE      = RTAG_ETHERTYPE_DFLT
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_mac_port_link,
  input  logic                           i_meta_vld,
  output logic                           o_meta_ready,
  input  logic                           i_meta_strip_vlan,
  input  logic                           i_meta_ins_vlan,
  input  logic [2:0]                     i_meta_vlan_pri,
  input  logic [11:0]                    i_meta_vlan_id,
  input  logic                           i_meta_ins_rtag,
  input  logic [15:0]                    i_meta_rtag_seq,
  input  logic [PORT_MNG_DATA_WIDTH-1:0] i_mac_axi_data,
  input  logic                           i_mac_axi_data_valid,
  output logic                           o_mac_axi_data_ready,
  input  logic                           i_mac_axi_data_last,
  output logic [PORT_MNG_DATA_WIDTH-1:0] o_mac_axi_data,
  output logic                           o_mac_axi_data_valid,
  input  logic                           i_mac_axi_data_ready,
  output logic                           o_mac_axi_data_last,
  output logic                           o_mac_axi_data_err,
  output logic                           o_frm_done,
  output logic [2:0]                     o_dbg_state
);

  localparam int W = PORT_MNG_DATA_WIDTH;

  tx_state_e    state_q, state_d;
  logic [3:0]   hdr_cnt_q, hdr_cnt_d;
  logic [2:0]   ins_cnt_q, ins_cnt_d;

  logic         m_strip_q, m_vlan_q, m_rtag_q;
  logic [2:0]   m_pri_q;
  logic [11:0]  m_vid_q;
  logic [15:0]  m_seq_q;

  logic         meta_ready, meta_take;
  logic         can_load, in_ready, in_fire;
  logic         ld, ld_last, ld_err;
  logic [W-1:0] ld_data;
  logic         done_d, done_q;
  logic [7:0]   vlan_byte, rtag_byte;

  // Input is accepted only in states that consume bytes. STRIP also waits
  // for register space because a runt ending there forwards its last byte.
  always_comb begin
    unique case (state_q)
      ST_ADDR, ST_STRIP, ST_PAYLOAD: in_ready = can_load;
      ST_DISCARD:                    in_ready = 1'b1;
      default:                       in_ready = 1'b0;
    endcase
  end

  assign in_fire = i_mac_axi_data_valid & in_ready;

  always_comb begin
    unique case (ins_cnt_q)
      3'd0:    vlan_byte = VLAN_TPID[15:8];
      3'd1:    vlan_byte = VLAN_TPID[7:0];
      3'd2:    vlan_byte = {m_pri_q, 1'b0, m_vid_q[11:8]};
      default: vlan_byte = m_vid_q[7:0];
    endcase
  end

  always_comb begin
    unique case (ins_cnt_q)
      3'd0:       rtag_byte = RTAG_ETHERTYPE[15:8];
      3'd1:       rtag_byte = RTAG_ETHERTYPE[7:0];
      3'd2, 3'd3: rtag_byte = 8'h00;
      3'd4:       rtag_byte = m_seq_q[15:8];
      default:    rtag_byte = m_seq_q[7:0];
    endcase
  end

  // Next state, counters and output register load.
  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    ins_cnt_d  = ins_cnt_q;
    meta_ready = 1'b0;
    meta_take  = 1'b0;
    ld         = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    ld_err     = 1'b0;
    done_d     = o_mac_axi_data_valid & i_mac_axi_data_ready & o_mac_axi_data_last;

    unique case (state_q)
      ST_IDLE: begin
        meta_ready = 1'b1;
        if (i_meta_vld) begin
          meta_take = 1'b1;
          hdr_cnt_d = '0;
          state_d   = i_mac_port_link ? ST_ADDR : ST_DISCARD;
        end
      end

      ST_ADDR: begin
        if (in_fire) begin
          ld      = 1'b1;
          ld_data = i_mac_axi_data;
          ld_last = i_mac_axi_data_last;
          // A frame ending inside the address bytes is a runt: abort it.
          ld_err  = i_mac_axi_data_last;
          if (i_mac_axi_data_last) begin
            state_d = ST_IDLE;
          end else if (hdr_cnt_q == SMAC_END) begin
            hdr_cnt_d = '0;
            ins_cnt_d = '0;
            state_d   = m_strip_q ? ST_STRIP : tag_next(m_vlan_q, m_rtag_q);
          end else begin
            hdr_cnt_d = hdr_cnt_q + 4'd1;
          end
        end
      end

      ST_STRIP: begin
        if (in_fire) begin
          if (i_mac_axi_data_last) begin
            ld      = 1'b1;
            ld_data = i_mac_axi_data;
            ld_last = 1'b1;
            ld_err  = 1'b1;
            state_d = ST_IDLE;
          end else if (hdr_cnt_q == 4'(TAG_LEN - 1)) begin
            ins_cnt_d = '0;
            state_d   = tag_next(m_vlan_q, m_rtag_q);
          end else begin
            hdr_cnt_d = hdr_cnt_q + 4'd1;
          end
        end
      end

      ST_INS_VLAN: begin
        if (can_load) begin
          ld      = 1'b1;
          ld_data = W'(vlan_byte);
          if (ins_cnt_q == 3'(TAG_LEN - 1)) begin
            ins_cnt_d = '0;
            state_d   = m_rtag_q ? ST_INS_RTAG : ST_PAYLOAD;
          end else begin
            ins_cnt_d = ins_cnt_q + 3'd1;
          end
        end
      end

      ST_INS_RTAG: begin
        if (can_load) begin
          ld      = 1'b1;
          ld_data = W'(rtag_byte);
          if (ins_cnt_q == 3'(RTAG_LEN - 1)) begin
            ins_cnt_d = '0;
            state_d   = ST_PAYLOAD;
          end else begin
            ins_cnt_d = ins_cnt_q + 3'd1;
          end
        end
      end

      ST_PAYLOAD: begin
        if (in_fire) begin
          ld      = 1'b1;
          ld_data = i_mac_axi_data;
          ld_last = i_mac_axi_data_last;
          if (i_mac_axi_data_last) state_d = ST_IDLE;
        end
      end

      ST_DISCARD: begin
        if (in_fire && i_mac_axi_data_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      hdr_cnt_q <= '0;
      ins_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      ins_cnt_q <= ins_cnt_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_strip_q <= 1'b0;
      m_vlan_q  <= 1'b0;
      m_rtag_q  <= 1'b0;
      m_pri_q   <= '0;
      m_vid_q   <= '0;
      m_seq_q   <= '0;
    end else if (meta_take) begin
      m_strip_q <= i_meta_strip_vlan;
      m_vlan_q  <= i_meta_ins_vlan;
      m_rtag_q  <= i_meta_ins_rtag;
      m_pri_q   <= i_meta_vlan_pri;
      m_vid_q   <= i_meta_vlan_id;
      m_seq_q   <= i_meta_rtag_seq;
    end
  end

  axis_byte_reg #(.W(W)) u_out_reg (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (ld),
    .load_data (ld_data),
    .load_last (ld_last),
    .load_err  (ld_err),
    .can_load  (can_load),
    .out_data  (o_mac_axi_data),
    .out_valid (o_mac_axi_data_valid),
    .out_last  (o_mac_axi_data_last),
    .out_err   (o_mac_axi_data_err),
    .out_ready (i_mac_axi_data_ready)
  );

  // Metadata is refused while reset is held, even though the FSM sits in IDLE.
  assign o_meta_ready         = meta_ready & ~i_rst;
  assign o_mac_axi_data_ready = in_ready;
  assign o_frm_done           = done_q;
  assign o_dbg_state          = state_q;

endmodule

// File: tb/tb_tx_frm_tag_edit.sv
// -----------------------------------------------------------------------------
// tb_tx_frm_tag_edit
// Directed and randomized frames through the header editor. Expected output
// bytes are built from the frame editing rules into exp_q and compared at
// every output handshake; frame-done pulses, latency and reset values are
// checked as well.
// -----------------------------------------------------------------------------
module tb_tx_frm_tag_edit;

  logic        clk = 1'b0;
  logic        rst;
  logic        link;
  logic        meta_vld;
  logic        meta_ready;
  logic        meta_strip, meta_vlan, meta_rtag;
  logic [2:0]  meta_pri;
  logic [11:0] meta_vid;
  logic [15:0] meta_seq;
  logic [7:0]  in_data;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  out_data;
  logic        out_valid, out_last, out_err;
  logic        ds_ready;
  logic        frm_done;
  logic [2:0]  dbg_state;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [9:0]  exp_q[$];
  logic [7:0]  frm[$];
  int          exp_done = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  bit          rand_rdy = 1'b0;
  bit          lat_arm = 1'b0;
  int          lat_in = -1;
  int          lat_out = -1;

  tx_frm_tag_edit dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_mac_port_link      (link),
    .i_meta_vld           (meta_vld),
    .o_meta_ready         (meta_ready),
    .i_meta_strip_vlan    (meta_strip),
    .i_meta_ins_vlan      (meta_vlan),
    .i_meta_vlan_pri      (meta_pri),
    .i_meta_vlan_id       (meta_vid),
    .i_meta_ins_rtag      (meta_rtag),
    .i_meta_rtag_seq      (meta_seq),
    .i_mac_axi_data       (in_data),
    .i_mac_axi_data_valid (in_valid),
    .o_mac_axi_data_ready (in_ready),
    .i_mac_axi_data_last  (in_last),
    .o_mac_axi_data       (out_data),
    .o_mac_axi_data_valid (out_valid),
    .i_mac_axi_data_ready (ds_ready),
    .o_mac_axi_data_last  (out_last),
    .o_mac_axi_data_err   (out_err),
    .o_frm_done           (frm_done),
    .o_dbg_state          (dbg_state)
  );

  // ---------------- clock / reset block ----------------
  initial forever #2 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  // Downstream ready: always 1 or random, changed just after each rising edge.
  initial begin
    ds_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ds_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [9:0] exp_v;
    logic [9:0] obs_v;
    cyc++;
    if (!rst) begin
      if (frm_done) done_cnt++;
      if (lat_arm && lat_in < 0 && in_valid && in_ready) lat_in = cyc;
      if (lat_arm && lat_out < 0 && out_valid) lat_out = cyc;
      if (out_valid && ds_ready) begin
        n_cmp++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL out_unexpected observed=%0h expected=no_byte", {out_last, out_err, out_data});
        end
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          obs_v = {out_last, out_err, out_data};
          n_cmp++;
          assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL out_byte observed={last,err,data}=%0h expected=%0h", obs_v, exp_v);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: the edited frame as a whole, from the editing rules.
  task automatic model(input bit strip, input bit vlan, input logic [2:0] pri,
                       input logic [11:0] vid, input bit rtag, input logic [15:0] seq,
                       input bit lnk);
    logic [7:0] o[$];
    bit runt;
    int n;
    n = frm.size();
    runt = 1'b0;
    if (!lnk) return;
    if (n <= 12) begin
      o = frm;
      runt = 1'b1;
    end else if (strip && n <= 16) begin
      for (int i = 0; i < 12; i++) o.push_back(frm[i]);
      o.push_back(frm[n-1]);
      runt = 1'b1;
    end else begin
      for (int i = 0; i < 12; i++) o.push_back(frm[i]);
      if (vlan) begin
        o.push_back(8'h81); o.push_back(8'h00);
        o.push_back({pri, 1'b0, vid[11:8]}); o.push_back(vid[7:0]);
      end
      if (rtag) begin
        o.push_back(8'hF1); o.push_back(8'hC1); o.push_back(8'h00); o.push_back(8'h00);
        o.push_back(seq[15:8]); o.push_back(seq[7:0]);
      end
      for (int i = (strip ? 16 : 12); i < n; i++) o.push_back(frm[i]);
    end
    for (int i = 0; i < o.size(); i++) begin
      bit lst;
      lst = (i == o.size() - 1);
      exp_q.push_back({lst, runt & lst, o[i]});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_frame(input int len, input bit strip, input bit vlan,
                            input logic [2:0] pri, input logic [11:0] vid,
                            input bit rtag, input logic [15:0] seq,
                            input bit lnk, input bit gaps);
    int budget;
    bit ok;
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
    if (strip && len >= 14) begin
      frm[12] = 8'h81;
      frm[13] = 8'h00;
    end
    model(strip, vlan, pri, vid, rtag, seq, lnk);
    exp_done++;

    meta_strip = strip; meta_vlan = vlan; meta_pri = pri; meta_vid = vid;
    meta_rtag = rtag; meta_seq = seq; link = lnk; meta_vld = 1'b1;
    budget = 50;
    do begin
      @(negedge clk); ok = meta_ready;
      @(posedge clk); #1; budget--;
    end while (!ok && budget > 0);
    meta_vld = 1'b0;
    check("meta_handshake", ok, 1);
    // Link changes after the handshake must not matter.
    link = 1'b1;

    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      in_data = frm[i]; in_last = (i == len - 1); in_valid = 1'b1;
      budget = 100;
      do begin
        @(negedge clk); ok = in_ready;
        @(posedge clk); #1; budget--;
      end while (!ok && budget > 0);
      in_valid = 1'b0; in_last = 1'b0;
      if (!ok) begin
        check("in_handshake", ok, 1);
        break;
      end
    end

    budget = 500;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk); budget--;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("frm_done_count", done_cnt, exp_done);
    check("back_to_idle", dbg_state, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; link = 1'b1; meta_vld = 1'b0;
    meta_strip = 1'b0; meta_vlan = 1'b0; meta_rtag = 1'b0;
    meta_pri = '0; meta_vid = '0; meta_seq = '0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_meta_ready", meta_ready, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_err", out_err, 0);
    check("rst_frm_done", frm_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_meta_ready", meta_ready, 1);
    check("post_rst_in_ready", in_ready, 0);
    check("post_rst_state", dbg_state, 0);
    @(posedge clk); #1;

    // Plain 64-byte frame, full throughput, one-cycle latency.
    lat_arm = 1'b1;
    send_frame(64, 0, 0, 3'd0, 12'h000, 0, 16'h0000, 1, 0);
    lat_arm = 1'b0;
    check("latency_cycles", lat_out - lat_in, 1);

    // VLAN insertion.
    send_frame(64, 0, 1, 3'd5, 12'h123, 0, 16'h0000, 1, 0);
    // Retag: strip then insert.
    send_frame(68, 1, 1, 3'd2, 12'h064, 0, 16'h0000, 1, 1);
    // VLAN + R-TAG with random downstream ready.
    rand_rdy = 1'b1;
    send_frame(64, 0, 1, 3'd7, 12'hABC, 1, 16'hBEEF, 1, 1);
    // R-TAG only, and strip only.
    send_frame(40, 0, 0, 3'd0, 12'h000, 1, 16'h1234, 1, 1);
    send_frame(40, 1, 0, 3'd0, 12'h000, 0, 16'h0000, 1, 1);
    // Link down: consumed and discarded.
    send_frame(64, 0, 1, 3'd1, 12'h001, 1, 16'h5555, 0, 1);
    // Runts: inside the address bytes, and inside the stripped tag.
    send_frame(8, 0, 1, 3'd3, 12'h321, 1, 16'h0101, 1, 0);
    send_frame(14, 1, 1, 3'd3, 12'h321, 0, 16'h0000, 1, 1);
    send_frame(12, 0, 1, 3'd0, 12'h0FF, 0, 16'h0000, 1, 0);
    send_frame(16, 1, 0, 3'd0, 12'h000, 1, 16'h0202, 1, 0);
    send_frame(17, 1, 1, 3'd6, 12'hFED, 1, 16'h0303, 1, 1);

    // Random frames.
    for (int k = 0; k < 12; k++) begin
      send_frame($urandom_range(1, 80), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)),
                 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                 ($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
